// File: rtl/job_dispatcher.sv
`default_nettype none
// ---------------------------------------------------------------------------
// job_dispatcher : queues job requests and runs one job at a time on a
//                  go/kill/done engine, tracking ok/error statistics.
// Revision: 1.0
// ---------------------------------------------------------------------------
module job_dispatcher #(
   parameter int MAX_PEND  = 4,
   parameter int TIMEOUT   = 200,
   parameter int KILL_HOLD = 2,
   parameter int CNT_W     = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req,
   input  logic             cancel,
   input  logic             done,
   output logic             go,
   output logic             kill,
   output logic             busy,
   output logic             job_ok,
   output logic             job_err,
   output logic             timeout_flag,
   output logic             overflow,
   output logic [3:0]       pending,
   output logic [CNT_W-1:0] ok_count,
   output logic [CNT_W-1:0] err_count
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LAUNCH = 3'd1,
      S_WAIT   = 3'd2,
      S_KILL   = 3'd3,
      S_DRAIN  = 3'd4
   } state_t;

   state_t           state_q;
   logic [3:0]       pending_q, pending_d;
   logic [8:0]       timer_q;
   logic [2:0]       hold_q;
   logic             cxl_q;
   logic             go_q, kill_q, ok_q, err_q, tof_q, ovf_q;
   logic [CNT_W-1:0] okc_q, errc_q;
   logic             deq_w, ovf_set_w;

   // A launch consumes one queued request; a same-cycle req refills the slot.
   always_comb begin
      deq_w     = (state_q == S_IDLE) && (pending_q != 4'd0) && !cancel;
      pending_d = pending_q;
      ovf_set_w = 1'b0;
      if (cancel) begin
         pending_d = 4'd0;
      end else if (deq_w) begin
         if (!req) pending_d = pending_q - 4'd1;
      end else if (req) begin
         if (pending_q < 4'(MAX_PEND)) pending_d = pending_q + 4'd1;
         else                          ovf_set_w = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         pending_q <= 4'd0;
         timer_q   <= 9'd0;
         hold_q    <= 3'd0;
         cxl_q     <= 1'b0;
         go_q      <= 1'b0;
         kill_q    <= 1'b0;
         ok_q      <= 1'b0;
         err_q     <= 1'b0;
         tof_q     <= 1'b0;
         ovf_q     <= 1'b0;
         okc_q     <= '0;
         errc_q    <= '0;
      end else begin
         pending_q <= pending_d;
         if (ovf_set_w) ovf_q <= 1'b1;
         go_q  <= 1'b0;
         ok_q  <= 1'b0;
         err_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (deq_w) begin
                  state_q <= S_LAUNCH;
                  go_q    <= 1'b1;
                  cxl_q   <= 1'b0;
               end
            end
            S_LAUNCH: begin
               // A cancel seen while go is out is remembered for the first WAIT cycle.
               state_q <= S_WAIT;
               timer_q <= 9'd0;
               if (cancel) cxl_q <= 1'b1;
            end
            S_WAIT: begin
               if (done) begin
                  state_q <= S_IDLE;
                  ok_q    <= 1'b1;
                  okc_q   <= okc_q + 1'b1;
               end else if (cancel || cxl_q) begin
                  state_q <= S_KILL;
                  kill_q  <= 1'b1;
                  hold_q  <= 3'd0;
               end else if (timer_q == 9'(TIMEOUT - 1)) begin
                  state_q <= S_KILL;
                  kill_q  <= 1'b1;
                  hold_q  <= 3'd0;
                  tof_q   <= 1'b1;
               end else begin
                  timer_q <= timer_q + 9'd1;
               end
            end
            S_KILL: begin
               if (hold_q == 3'(KILL_HOLD - 1)) begin
                  state_q <= S_DRAIN;
                  kill_q  <= 1'b0;
                  err_q   <= 1'b1;
                  errc_q  <= errc_q + 1'b1;
               end else begin
                  hold_q <= hold_q + 3'd1;
               end
            end
            S_DRAIN: state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign go           = go_q;
   assign kill         = kill_q;
   assign busy         = (state_q != S_IDLE);
   assign job_ok       = ok_q;
   assign job_err      = err_q;
   assign timeout_flag = tof_q;
   assign overflow     = ovf_q;
   assign pending      = pending_q;
   assign ok_count     = okc_q;
   assign err_count    = errc_q;

endmodule
`default_nettype wire

// File: tb/tb_job_dispatcher.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_job_dispatcher : directed and random scenarios against a job-level model.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_job_dispatcher;

   localparam int MAX_PEND = 4;
   localparam int TIMEOUT  = 200;
   localparam int KH       = 2;
   localparam int CNT_W    = 8;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic req = 1'b0, cancel = 1'b0, done = 1'b0;
   logic go, kill, busy, job_ok, job_err, timeout_flag, overflow;
   logic [3:0] pending;
   logic [CNT_W-1:0] ok_count, err_count;

   int n_vec = 0;
   int n_err = 0;

   job_dispatcher #(.MAX_PEND(MAX_PEND), .TIMEOUT(TIMEOUT), .KILL_HOLD(KH), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .req(req), .cancel(cancel), .done(done),
      .go(go), .kill(kill), .busy(busy), .job_ok(job_ok), .job_err(job_err),
      .timeout_flag(timeout_flag), .overflow(overflow), .pending(pending),
      .ok_count(ok_count), .err_count(err_count));

   always #5 clk = ~clk;

   // Job-level reference: m_t counts cycles since go, m_abort is the m_t at
   // which kill first rises (-1 while no abort is scheduled).
   int m_pend, m_okc, m_errc, m_t, m_abort;
   bit m_ovf, m_tof, m_job, m_cx, m_ok;

   function automatic void model_reset();
      m_pend = 0; m_okc = 0; m_errc = 0; m_t = 0; m_abort = -1;
      m_ovf = 0; m_tof = 0; m_job = 0; m_cx = 0; m_ok = 0;
   endfunction

   function automatic void model_step(input bit r, input bit c, input bit d);
      bit idle, deq;
      idle = !m_job;
      deq  = idle && (m_pend > 0) && !c;
      if (c)             m_pend = 0;
      else if (deq)      m_pend = r ? m_pend : m_pend - 1;
      else if (r) begin
         if (m_pend < MAX_PEND) m_pend++;
         else                   m_ovf = 1;
      end
      m_ok = 0;
      if (idle) begin
         if (deq) begin m_job = 1; m_t = 0; m_abort = -1; m_cx = 0; end
      end else if (m_abort < 0) begin
         if (m_t == 0) begin
            m_cx = c;
            m_t  = 1;
         end else if (d) begin
            m_job = 0; m_ok = 1; m_okc++;
         end else begin
            if (c || m_cx) m_abort = m_t + 1;
            else if (m_t - 1 == TIMEOUT - 1) begin m_abort = m_t + 1; m_tof = 1; end
            m_t++;
         end
      end else begin
         if (m_t == m_abort + KH) m_job = 0;
         else begin
            if (m_t == m_abort + KH - 1) m_errc++;
            m_t++;
         end
      end
   endfunction

   function automatic logic [26:0] model_vec();
      logic e_go, e_kill, e_err;
      e_go   = m_job && (m_t == 0);
      e_kill = m_job && (m_abort >= 0) && (m_t >= m_abort) && (m_t < m_abort + KH);
      e_err  = m_job && (m_abort >= 0) && (m_t == m_abort + KH);
      return {e_go, e_kill, m_job, m_ok, e_err, m_tof, m_ovf, 4'(m_pend), 8'(m_okc), 8'(m_errc)};
   endfunction

   function automatic logic [26:0] dut_vec();
      return {go, kill, busy, job_ok, job_err, timeout_flag, overflow, pending, ok_count, err_count};
   endfunction

   task automatic cycle(input bit r, input bit c, input bit d);
      req = r; cancel = c; done = d;
      @(posedge clk);
      model_step(r, c, d);
      #1;
   endtask

   task automatic apply_reset();
      reset = 1'b0; req = 1'b0; cancel = 1'b0; done = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b1;
      model_reset();
   endtask

   task automatic test_reset();
      logic [26:0] obs;
      apply_reset();
      for (int i = 0; i < 40; i++) cycle(($urandom % 2) == 1, 1'b0, 1'b0);
      #2 reset = 1'b0;
      #1 obs = dut_vec();
      n_vec++;
      if (obs !== 27'h0) begin
         n_err++; $display("FAIL reset_async: dut=%h required=%h", obs, 27'h0);
      end
      @(posedge clk); #1;
      obs = dut_vec();
      n_vec++;
      if (obs !== 27'h0) begin
         n_err++; $display("FAIL reset_held: dut=%h required=%h", obs, 27'h0);
      end
      reset = 1'b1;
      model_reset();
   endtask

   task automatic test_single();
      int g = -1, ok_at = -1, gos = 0;
      logic [26:0] obs, exp;
      apply_reset();
      cycle(1'b1, 1'b0, 1'b0);
      for (int i = 1; i < 400; i++) begin
         cycle(1'b0, 1'b0, (g >= 0) && (i == g + 104));
         obs = dut_vec(); exp = model_vec(); n_vec++;
         if (obs !== exp) begin
            n_err++; $display("FAIL single_cyc%0d: dut=%h model=%h", i, obs, exp);
         end
         if (go) begin gos++; g = i; end
         if (job_ok) ok_at = i;
         if (ok_at >= 0 && i > ok_at + 3) break;
      end
      n_vec++;
      if (gos !== 1 || ok_at !== g + 104 || ok_count !== 8'd1 || pending !== 4'd0 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL single_summary: gos=%0d ok_at=%0d go_at=%0d okc=%0d pend=%0d busy=%b required gos=1 ok_at=go+104 okc=1 pend=0 busy=0",
                  gos, ok_at, g, ok_count, pending, busy);
      end
   endtask

   task automatic test_burst();
      int g = -1, gos = 0, oks = 0;
      logic [26:0] obs, exp;
      apply_reset();
      for (int i = 0; i < 1200; i++) begin
         cycle(i < 6, 1'b0, (g >= 0) && (i == g + 104));
         obs = dut_vec(); exp = model_vec(); n_vec++;
         if (obs !== exp) begin
            n_err++; $display("FAIL burst_cyc%0d: dut=%h model=%h", i, obs, exp);
         end
         if (go) begin gos++; g = i; end
         if (job_ok) oks++;
         if (oks == 5 && !busy) break;
      end
      n_vec++;
      if (gos !== 5 || ok_count !== 8'd5 || overflow !== 1'b1 || pending !== 4'd0) begin
         n_err++;
         $display("FAIL burst_summary: gos=%0d okc=%0d ovf=%b pend=%0d required gos=5 okc=5 ovf=1 pend=0",
                  gos, ok_count, overflow, pending);
      end
   endtask

   task automatic test_timeout();
      int g = -1, k = -1, kh = 0, e_at = -1;
      logic [26:0] obs, exp;
      apply_reset();
      cycle(1'b1, 1'b0, 1'b0);
      for (int i = 1; i < 400; i++) begin
         cycle(1'b0, 1'b0, 1'b0);
         obs = dut_vec(); exp = model_vec(); n_vec++;
         if (obs !== exp) begin
            n_err++; $display("FAIL timeout_cyc%0d: dut=%h model=%h", i, obs, exp);
         end
         if (go) g = i;
         if (kill) begin kh++; if (k < 0) k = i; end
         if (job_err) e_at = i;
         if (e_at >= 0 && i > e_at + 2) break;
      end
      n_vec++;
      if (k - g !== 201 || kh !== 2 || e_at !== k + 2 || err_count !== 8'd1 || timeout_flag !== 1'b1) begin
         n_err++;
         $display("FAIL timeout_summary: kill_after_go=%0d kill_len=%0d err_after_kill=%0d errc=%0d tof=%b required 201 2 2 1 1",
                  k - g, kh, e_at - k, err_count, timeout_flag);
      end
   endtask

   task automatic test_cancel();
      int g = -1, gos = 0, kh = 0, errs = 0;
      logic [26:0] obs, exp;
      apply_reset();
      for (int i = 0; i < 4; i++) begin
         cycle(1'b1, 1'b0, 1'b0);
         if (go) g = i;
      end
      for (int i = 4; i < 200; i++) begin
         cycle(1'b0, (g >= 0) && (i == g + 51), 1'b0);
         obs = dut_vec(); exp = model_vec(); n_vec++;
         if (obs !== exp) begin
            n_err++; $display("FAIL cancel_cyc%0d: dut=%h model=%h", i, obs, exp);
         end
         if (go) begin g = i; gos++; end
         if (g >= 0 && i == g + 50) begin
            n_vec++;
            if (pending !== 4'd3) begin
               n_err++; $display("FAIL cancel_pre_pending: dut=%0d required=3", pending);
            end
         end
         if (g >= 0 && i == g + 51) begin
            n_vec++;
            if (pending !== 4'd0) begin
               n_err++; $display("FAIL cancel_flush: dut=%0d required=0", pending);
            end
         end
         if (kill) kh++;
         if (job_err) errs++;
      end
      n_vec++;
      if (gos !== 0 || kh !== 2 || errs !== 1 || timeout_flag !== 1'b0 || err_count !== 8'd1) begin
         n_err++;
         $display("FAIL cancel_summary: extra_go=%0d kill_len=%0d errs=%0d tof=%b errc=%0d required 0 2 1 0 1",
                  gos, kh, errs, timeout_flag, err_count);
      end
   endtask

   task automatic test_done_cancel();
      int g = -1, kh = 0, oks = 0;
      logic [26:0] obs, exp;
      apply_reset();
      cycle(1'b1, 1'b0, 1'b0);
      for (int i = 1; i < 60; i++) begin
         cycle(1'b0, (g >= 0) && (i == g + 20), (g >= 0) && (i == g + 20));
         obs = dut_vec(); exp = model_vec(); n_vec++;
         if (obs !== exp) begin
            n_err++; $display("FAIL donecxl_cyc%0d: dut=%h model=%h", i, obs, exp);
         end
         if (go) g = i;
         if (kill) kh++;
         if (job_ok) oks++;
      end
      n_vec++;
      if (oks !== 1 || kh !== 0 || err_count !== 8'd0 || ok_count !== 8'd1) begin
         n_err++;
         $display("FAIL donecxl_summary: oks=%0d kill_cycles=%0d errc=%0d okc=%0d required 1 0 0 1",
                  oks, kh, err_count, ok_count);
      end
   endtask

   task automatic test_reset_in_kill();
      int g = -1;
      bit hit = 0;
      apply_reset();
      cycle(1'b1, 1'b0, 1'b0);
      for (int i = 1; i < 40; i++) begin
         cycle(1'b0, (g >= 0) && (i == g + 5), 1'b0);
         if (go) g = i;
         if (kill) begin hit = 1; break; end
      end
      n_vec++;
      if (!hit) begin
         n_err++; $display("FAIL rstkill_reach: kill=0 required=1");
      end
      #2 reset = 1'b0;
      #1;
      n_vec++;
      if ({go, kill, busy} !== 3'b000) begin
         n_err++; $display("FAIL rstkill_drop: go/kill/busy=%b required=000", {go, kill, busy});
      end
      @(posedge clk); #1;
      reset = 1'b1;
      model_reset();
      cycle(1'b1, 1'b0, 1'b0);
      n_vec++;
      if (go !== 1'b0 || pending !== 4'd1) begin
         n_err++; $display("FAIL rstkill_queue: go=%b pend=%0d required go=0 pend=1", go, pending);
      end
      cycle(1'b0, 1'b0, 1'b0);
      n_vec++;
      if (go !== 1'b1 || ok_count !== 8'd0 || err_count !== 8'd0 || timeout_flag !== 1'b0) begin
         n_err++;
         $display("FAIL rstkill_relaunch: go=%b okc=%0d errc=%0d tof=%b required go=1 okc=0 errc=0 tof=0",
                  go, ok_count, err_count, timeout_flag);
      end
   endtask

   task automatic test_random();
      logic [26:0] obs, exp;
      apply_reset();
      for (int i = 0; i < 3000; i++) begin
         if (i < 1500)
            cycle(($urandom % 4) == 0, ($urandom % 60) == 0, ($urandom % 30) == 0);
         else
            cycle(($urandom % 2) == 0, ($urandom % 150) == 0, ($urandom % 250) == 0);
         obs = dut_vec(); exp = model_vec(); n_vec++;
         if (obs !== exp) begin
            n_err++; $display("FAIL random_cyc%0d: dut=%h model=%h", i, obs, exp);
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_single();
      test_burst();
      test_timeout();
      test_cancel();
      test_done_cancel();
      test_reset_in_kill();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
